// File: rtl/neg_te.sv
// Balanced-ternary negation with a one-clock registered result and invalid-trit flag.
// Build option: define NEG_TE_ERR_STICKY_EN to hold err high from the first invalid trit until reset.
module neg_te #(
    parameter logic [1:0] ERR_C = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] a,
    output logic [1:0] c,
    output logic       err
);

    // 2'b11 is not a legal trit, so it can never be the substitute value either.
    localparam logic [1:0] err_val = (ERR_C == 2'b11) ? 2'b00 : ERR_C;

    logic [1:0] c_d;
    logic       inv;
    logic       err_d;

    // Anything other than the three legal codes, X included, takes the invalid path.
    always_comb begin
        c_d = err_val;
        inv = 1'b1;
        case (a)
            2'b10: begin
                c_d = 2'b01;
                inv = 1'b0;
            end
            2'b00: begin
                c_d = 2'b00;
                inv = 1'b0;
            end
            2'b01: begin
                c_d = 2'b10;
                inv = 1'b0;
            end
            default: begin
                c_d = err_val;
                inv = 1'b1;
            end
        endcase
    end

`ifdef NEG_TE_ERR_STICKY_EN
    assign err_d = inv | err;
`else
    assign err_d = inv;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            c   <= 2'b00;
            err <= 1'b0;
        end else begin
            c   <= c_d;
            err <= err_d;
        end
    end

endmodule

// File: tb/tb_neg_te.sv
// Randomised bench for neg_te: three instances (ERR_C = 00, 01, 11) checked against a trit-level model.
module tb_neg_te;

`ifdef NEG_TE_ERR_STICKY_EN
    localparam bit sticky = 1'b1;
`else
    localparam bit sticky = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a;
    logic [1:0] c [3];
    logic       e [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    neg_te u_dut0 (.clk(clk), .rst(rst), .a(a), .c(c[0]), .err(e[0]));
    neg_te #(.ERR_C(2'b01)) u_dut1 (.clk(clk), .rst(rst), .a(a), .c(c[1]), .err(e[1]));
    neg_te #(.ERR_C(2'b11)) u_dut2 (.clk(clk), .rst(rst), .a(a), .c(c[2]), .err(e[2]));

    // Trit-level reference: values as integers, negation as arithmetic.
    function automatic int trit_val(input logic [1:0] t);
        if (t == 2'b10) return 1;
        if (t == 2'b01) return -1;
        return 0;
    endfunction

    function automatic logic [1:0] trit_enc(input int v);
        if (v == 1) return 2'b10;
        if (v == -1) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] model_c(input logic [1:0] t, input logic [1:0] errc);
        if (t == 2'b11) return (errc == 2'b11) ? 2'b00 : errc;
        return trit_enc(-trit_val(t));
    endfunction

    logic [1:0] errc_tab [3];
    logic [1:0] exp_c [3];
    logic       exp_err;
    bit         chk_en = 1'b0;

    initial begin
        errc_tab[0] = 2'b00;
        errc_tab[1] = 2'b01;
        errc_tab[2] = 2'b11;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) exp_c[k] = 2'b00;
            exp_err = 1'b0;
            chk_en  = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) exp_c[k] = model_c(a, errc_tab[k]);
            exp_err = (a == 2'b11) || (sticky && exp_err);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (c[k] !== exp_c[k] || e[k] !== exp_err) begin
                    fails++;
                    $display("FAIL model dut%0d t=%0t: c=%b err=%b, expected c=%b err=%b",
                             k, $time, c[k], e[k], exp_c[k], exp_err);
                end
            end
        end
    end

    task automatic lit(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive inputs now (a falling edge), then return at the next falling edge.
    task automatic cyc(input logic [1:0] av, input logic r);
        a   = av;
        rst = r;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] ra;
        logic       rr;

        cyc(2'b10, 1'b1);
        cyc(2'b10, 1'b1);
        lit("reset_c", c[0], 2'b00);
        lit("reset_err", {1'b0, e[0]}, 2'b00);

        cyc(2'b10, 1'b0);
        lit("seq_p1_c", c[0], 2'b01);
        lit("seq_p1_err", {1'b0, e[0]}, 2'b00);
        cyc(2'b00, 1'b0);
        lit("seq_z_c", c[0], 2'b00);
        cyc(2'b01, 1'b0);
        lit("seq_m1_c", c[0], 2'b10);
        lit("seq_m1_err", {1'b0, e[0]}, 2'b00);
        cyc(2'b11, 1'b0);
        lit("seq_inv_c", c[0], 2'b00);
        lit("seq_inv_err", {1'b0, e[0]}, 2'b01);
        lit("errc01_c", c[1], 2'b01);
        lit("errc01_err", {1'b0, e[1]}, 2'b01);
        lit("errc11_c", c[2], 2'b00);

        cyc(2'b01, 1'b0);
        lit("recover_c", c[0], 2'b10);
        lit("recover_err", {1'b0, e[0]}, {1'b0, sticky});

        cyc(2'b11, 1'b0);
        cyc(2'b10, 1'b0);
        lit("hold_p1_c", c[0], 2'b01);
        lit("hold_p1_err", {1'b0, e[0]}, {1'b0, sticky});
        cyc(2'b00, 1'b0);
        lit("hold_z_c", c[0], 2'b00);
        lit("hold_z_err", {1'b0, e[0]}, {1'b0, sticky});
        cyc(2'b11, 1'b1);
        lit("hold_rst_err", {1'b0, e[0]}, 2'b00);

        cyc(2'b01, 1'b1);
        lit("mid_rst_c", c[0], 2'b00);
        lit("mid_rst_err", {1'b0, e[0]}, 2'b00);
        cyc(2'b01, 1'b0);
        lit("after_rst_c", c[0], 2'b10);

        // Random trits with occasional resets; a is disturbed just after each edge.
        for (int i = 0; i < 400; i++) begin
            ra  = 2'($urandom_range(0, 3));
            rr  = ($urandom_range(0, 19) == 0);
            a   = ra;
            rst = rr;
            @(posedge clk);
            #1 a = 2'($urandom_range(0, 3));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neg_te.md
NEG_TE -- requirements
Module: neg_te

Interface
REQ-001 The block SHALL have one parameter: ERR_C, default 2'b00, the value driven on c when the input trit is invalid.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 The block SHALL have port a, input, 2 bits, the operand trit: 2'b10 = +1, 2'b00 = 0, 2'b01 = -1, 2'b11 = invalid.
REQ-005 The block SHALL have port c, output, 2 bits, the negated trit, registered, same encoding as a.
REQ-006 The block SHALL have port err, output, 1 bit, the invalid-input flag, registered.

Function
REQ-007 The block SHALL sample a on every rising clk edge while rst is low; there is no valid/ready handshake.
REQ-008 The block SHALL compute the next value of c from a as: 2'b10 -> 2'b01, 2'b00 -> 2'b00, 2'b01 -> 2'b10, 2'b11 -> ERR_C.
REQ-009 For valid inputs, negation SHALL equal swapping a[1] and a[0].
REQ-010 The next value of err SHALL be 1 when a == 2'b11, else 0, in the non-sticky build.
REQ-011 Latency SHALL be exactly one clock: c and err reflect the a sampled at the previous rising edge.
REQ-012 A new result SHALL be produced every cycle, giving a throughput of one trit per clock.
REQ-013 c SHALL never be driven to 2'b11, including when ERR_C is overridden with 2'b11.
- If ERR_C == 2'b11, the block SHALL drive 2'b00 instead.
REQ-014 Outputs SHALL hold their values between clock edges.
- Input changes between edges SHALL have no effect until the next edge.
REQ-015 Unknown or X on a SHALL be treated as invalid (err = 1, c = ERR_C) wherever synthesis semantics permit.
- In simulation, X is not required to propagate.

Reset
REQ-016 While rst is high at a rising edge, the block SHALL set c to 2'b00 and err to 0, regardless of a.
REQ-017 Reset SHALL take priority over all other updates, including the sticky error hold.
REQ-018 On the first edge after rst is deasserted, the block SHALL resume normal sampling per REQ-008/REQ-010.
REQ-019 Asserting rst mid-stream SHALL discard the in-flight result; no partial state survives.

Configuration
REQ-020 The block SHALL support the macro NEG_TE_ERR_STICKY_EN.
- When defined, err becomes sticky: once set by an invalid input, it stays 1 until a reset edge.
- In the sticky build, c continues to follow REQ-008 every cycle.
- When undefined, err follows REQ-010 cycle by cycle.
- The port list SHALL be identical in both builds.

Verification
REQ-021 Reset check: hold rst = 1 for 2 cycles with a = 2'b10 -> c = 2'b00, err = 0.
REQ-022 Sequence check: apply a = 10, 00, 01, 11 on consecutive cycles. The outputs SHALL be, one cycle later:
- c = 01, 00, 10, 00;
- err = 0, 0, 0, 1.
REQ-023 Non-sticky recovery (macro undefined): apply a = 11 then 01 -> err = 1 then 0, c = 00 then 10.
REQ-024 Sticky hold (macro defined): apply a = 11, then 10, 00 -> err stays 1 while c = 01, 00.
- Then assert rst for 1 cycle -> err = 0.
REQ-025 Parameter check: ERR_C = 2'b01, apply a = 11 -> c = 01, err = 1.
- With ERR_C = 2'b11, apply a = 11 -> c = 00.
REQ-026 Mid-stream reset: apply a = 01 and rst = 1 on the same edge -> c = 00, err = 0.
- On the next edge with rst = 0, c = 10.
